// File: rtl/flog_arbiter_if.sv
// Requester-side bus of flog_arbiter: N_REQ request channels and N_REQ response channels
// that share one result bus.
// Handshake: a beat transfers on a rising clk edge where valid and ready are both 1. The
// arbiter holds rsp_valid_o/rsp_data_o stable until the owner's rsp_ready_i takes the result.
interface flog_arbiter_if #(parameter int N_REQ = 4);
  logic [N_REQ-1:0]    req_valid_i;
  logic [16*N_REQ-1:0] req_data_i;
  logic [N_REQ-1:0]    req_ready_o;
  logic [N_REQ-1:0]    rsp_valid_o;
  logic [15:0]         rsp_data_o;
  logic [N_REQ-1:0]    rsp_ready_i;

  modport slave (
    input  req_valid_i, req_data_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_data_o
  );

  modport master (
    output req_valid_i, req_data_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o
  );
endinterface

// File: rtl/flog_arbiter.sv
// Round-robin front end that shares one bfloat16 log2 core among N_REQ requesters,
// with one operation in flight at a time and a timeout that returns a QNaN.
module flog_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  flog_arbiter_if.slave bus,
  output logic          core_valid_o,
  output logic          core_sign_o,
  output logic [7:0]    core_exp_o,
  output logic [6:0]    core_fract_o,
  input  logic          core_valid_i,
  input  logic          core_s_i,
  input  logic [7:0]    core_e_i,
  input  logic [6:0]    core_f_i,
  output logic          err_timeout_o,
  input  logic          err_clr_i,
  output logic [1:0]    o_dbg_state
);
  localparam int PW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          r_state, w_next;
  logic [PW-1:0]   r_ptr, r_owner, w_gidx, w_cand;
  logic            w_found, w_grant, w_core_hit, w_timeout;
  logic [15:0]     r_operand, r_result;
  logic [CW-1:0]   r_cnt;
  logic            r_err;
  logic [15:0]     w_ops [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_ops
    assign w_ops[g] = bus.req_data_i[16*g +: 16];
  end

  // Search starts at r_ptr and wraps; the first valid requester found wins.
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    w_cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_cand = PW'((int'(r_ptr) + k) % N_REQ);
      if (!w_found && bus.req_valid_i[w_cand]) begin
        w_found = 1'b1;
        w_gidx  = w_cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // All handshake outputs are forced low while rst is held, whatever the state.
  always_comb begin
    w_next          = r_state;
    w_grant         = 1'b0;
    w_core_hit      = 1'b0;
    w_timeout       = 1'b0;
    core_valid_o    = 1'b0;
    bus.req_ready_o = '0;
    bus.rsp_valid_o = '0;
    if (!rst) begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            w_grant         = 1'b1;
            bus.req_ready_o = N_REQ'(1) << w_gidx;
            w_next          = S_ISSUE;
          end
        end
        S_ISSUE: begin
          core_valid_o = 1'b1;
          w_next       = S_WAIT;
        end
        S_WAIT: begin
          if (core_valid_i) begin
            w_core_hit = 1'b1;
            w_next     = S_RESP;
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            w_timeout = 1'b1;
            w_next    = S_RESP;
          end
        end
        S_RESP: begin
          bus.rsp_valid_o = N_REQ'(1) << r_owner;
          if (bus.rsp_ready_i[r_owner]) w_next = S_IDLE;
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  // The core gets TIMEOUT full WAIT cycles to answer; an answer in the last one still wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr     <= '0;
      r_owner   <= '0;
      r_operand <= '0;
      r_result  <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_grant) begin
        r_operand <= w_ops[w_gidx];
        r_owner   <= w_gidx;
        r_ptr     <= (w_gidx == PW'(N_REQ - 1)) ? '0 : w_gidx + 1'b1;
      end
      if (r_state == S_ISSUE)     r_cnt <= '0;
      else if (r_state == S_WAIT) r_cnt <= r_cnt + 1'b1;
      if (w_core_hit)     r_result <= {core_s_i, core_e_i, core_f_i};
      else if (w_timeout) r_result <= 16'h7FC0;
      if (w_timeout)      r_err <= 1'b1;
      else if (err_clr_i) r_err <= 1'b0;
    end
  end

  assign core_sign_o    = r_operand[15];
  assign core_exp_o     = r_operand[14:7];
  assign core_fract_o   = r_operand[6:0];
  assign bus.rsp_data_o = rst ? 16'h0000 : r_result;
  assign err_timeout_o  = r_err;
  assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_flog_arbiter.sv
// Directed bench for flog_arbiter: a cycle-level behavioural model checks every output each
// cycle, and literal expectations pin the scenarios that matter most.
module tb_flog_arbiter;
  localparam int N   = 4;
  localparam int TMO = 32;

  logic       clk, rst;
  logic       core_valid_o, core_sign_o;
  logic [7:0] core_exp_o;
  logic [6:0] core_fract_o;
  logic       core_valid_i, core_s_i;
  logic [7:0] core_e_i;
  logic [6:0] core_f_i;
  logic       err_timeout_o, err_clr_i;
  logic [1:0] dbg_state;

  flog_arbiter_if #(.N_REQ(N)) bus ();

  flog_arbiter #(.N_REQ(N), .TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .core_valid_o (core_valid_o),
    .core_sign_o  (core_sign_o),
    .core_exp_o   (core_exp_o),
    .core_fract_o (core_fract_o),
    .core_valid_i (core_valid_i),
    .core_s_i     (core_s_i),
    .core_e_i     (core_e_i),
    .core_f_i     (core_f_i),
    .err_timeout_o(err_timeout_o),
    .err_clr_i    (err_clr_i),
    .o_dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // model state: one operation in flight, described by the cycles at which things happen
  int          cyc = 0;
  int          m_ptr = 0;
  logic        m_active = 1'b0;
  logic        m_has_res = 1'b0;
  logic        m_err = 1'b0;
  logic [1:0]  m_owner = '0;
  logic [15:0] m_operand = '0;
  logic [15:0] m_res = '0;
  int          m_issue = 0;
  int          m_res_cyc = 0;

  // observations used by the directed checks
  int          grant_q[$];
  int          core_pulses = 0;
  int          rsp_cycles = 0;
  logic [N-1:0] last_ready = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input int ptr, input logic [N-1:0] v);
    int r;
    logic [1:0] ix;
    r = -1;
    for (int k = N - 1; k >= 0; k--) begin
      ix = 2'((ptr + k) % N);
      if (v[ix]) r = int'(ix);
    end
    return r;
  endfunction

  // Compare this cycle's outputs with the model, then advance the model across the edge.
  task automatic model_eval();
    logic [N-1:0] e_ready, e_rsp;
    logic         e_core, tmo;
    int           g;
    cyc++;
    last_ready = bus.req_ready_o;
    for (int k = 0; k < N; k++)
      if (((bus.req_ready_o >> k) & 4'b0001) != 4'b0000) grant_q.push_back(k);
    if (core_valid_o) core_pulses++;
    if (bus.rsp_valid_o != '0) rsp_cycles++;
    if (rst) begin
      chk("rst_req_ready", 32'(bus.req_ready_o), 32'h0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'h0);
      chk("rst_core_valid", 32'(core_valid_o), 32'h0);
      chk("rst_rsp_data", 32'(bus.rsp_data_o), 32'h0);
      m_active = 1'b0;
      m_has_res = 1'b0;
      m_ptr = 0;
      m_err = 1'b0;
    end else begin
      e_ready = '0;
      e_rsp = '0;
      e_core = 1'b0;
      g = -1;
      tmo = 1'b0;
      if (!m_active) begin
        g = rr_pick(m_ptr, bus.req_valid_i);
        if (g >= 0) e_ready = 4'b0001 << g;
      end else begin
        e_core = (cyc == m_issue);
        if (m_has_res && cyc >= m_res_cyc) e_rsp = 4'b0001 << m_owner;
      end
      chk("req_ready", 32'(bus.req_ready_o), 32'(e_ready));
      chk("core_valid", 32'(core_valid_o), 32'(e_core));
      chk("rsp_valid", 32'(bus.rsp_valid_o), 32'(e_rsp));
      chk("err_timeout", 32'(err_timeout_o), 32'(m_err));
      if (e_rsp != '0) chk("rsp_data", 32'(bus.rsp_data_o), 32'(m_res));
      if (m_active && !m_has_res && cyc >= m_issue)
        chk("core_operand", 32'({core_sign_o, core_exp_o, core_fract_o}), 32'(m_operand));
      if (!m_active) begin
        if (g >= 0) begin
          m_active  = 1'b1;
          m_has_res = 1'b0;
          m_owner   = 2'(g);
          m_operand = 16'(bus.req_data_i >> (16 * g));
          m_issue   = cyc + 1;
          m_ptr     = (g + 1) % N;
        end
      end else if (!m_has_res) begin
        if (cyc > m_issue) begin
          if (core_valid_i) begin
            m_has_res = 1'b1;
            m_res     = {core_s_i, core_e_i, core_f_i};
            m_res_cyc = cyc + 1;
          end else if (cyc == m_issue + TMO) begin
            m_has_res = 1'b1;
            m_res     = 16'h7FC0;
            m_res_cyc = cyc + 1;
            tmo       = 1'b1;
          end
        end
      end else if (bus.rsp_ready_i[m_owner]) begin
        m_active = 1'b0;
      end
      if (tmo) m_err = 1'b1;
      else if (err_clr_i) m_err = 1'b0;
    end
  endtask

  // driver tasks
  task automatic step();
    @(negedge clk);
    model_eval();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic core_drive(input logic v, input logic [15:0] d);
    core_valid_i = v;
    {core_s_i, core_e_i, core_f_i} = d;
  endtask

  task automatic core_pulse(input logic [15:0] d);
    core_drive(1'b1, d);
    step();
    core_drive(1'b0, 16'h0000);
  endtask

  // Raise one requester's valid until it is granted; returns in the ISSUE cycle.
  task automatic send(input int i, input logic [15:0] d);
    logic got;
    got = 1'b0;
    bus.req_data_i  = (bus.req_data_i & ~(64'hFFFF << (16 * i))) | (64'(d) << (16 * i));
    bus.req_valid_i = bus.req_valid_i | (4'b0001 << i);
    for (int t = 0; t < 64 && !got; t++) begin
      step();
      got = |(last_ready & (4'b0001 << i));
    end
    bus.req_valid_i = bus.req_valid_i & ~(4'b0001 << i);
    chk("grant_seen", 32'(got), 32'h1);
  endtask

  task automatic wait_issue();
    logic seen;
    seen = 1'b0;
    for (int t = 0; t < 64 && !seen; t++) begin
      if (core_valid_o) seen = 1'b1;
      else step();
    end
    chk("issue_seen", 32'(seen), 32'h1);
  endtask

  int p0, rc0;

  initial begin
    rst = 1'b1;
    err_clr_i = 1'b0;
    core_drive(1'b0, 16'h0000);
    bus.req_valid_i = '0;
    bus.req_data_i  = '0;
    bus.rsp_ready_i = '0;
    steps(3);
    rst = 1'b0;
    bus.rsp_ready_i = 4'hF;
    chk("reset_err", 32'(err_timeout_o), 32'h0);
    chk("reset_rsp_data", 32'(bus.rsp_data_o), 32'h0);

    // requester 2 computes log2(2.0) with a 20-cycle core
    core_pulses = 0;
    send(2, 16'h4000);
    chk("t1_core_valid", 32'(core_valid_o), 32'h1);
    chk("t1_core_exp", 32'(core_exp_o), 32'h80);
    chk("t1_core_fract", 32'(core_fract_o), 32'h0);
    steps(20);
    core_pulse(16'h3F80);
    chk("t1_rsp_valid", 32'(bus.rsp_valid_o), 32'h4);
    chk("t1_rsp_data", 32'(bus.rsp_data_o), 32'h3F80);
    chk("t1_core_pulses", 32'(core_pulses), 32'h1);
    step();
    chk("t1_rsp_done", 32'(bus.rsp_valid_o), 32'h0);

    // all requesters valid straight out of reset: grants 0,1,2,3,0
    rst = 1'b1;
    bus.req_data_i  = {16'h4200, 16'h4100, 16'h4080, 16'h4000};
    bus.req_valid_i = 4'hF;
    steps(2);
    grant_q.delete();
    rst = 1'b0;
    for (int op = 0; op < 5; op++) begin
      wait_issue();
      steps(3);
      core_pulse(16'h3000 + 16'(op));
      step();
    end
    bus.req_valid_i = '0;
    chk("t2_grants", 32'(grant_q.size()), 32'd5);
    if (grant_q.size() == 5) begin
      chk("t2_g0", 32'(grant_q[0]), 32'd0);
      chk("t2_g1", 32'(grant_q[1]), 32'd1);
      chk("t2_g2", 32'(grant_q[2]), 32'd2);
      chk("t2_g3", 32'(grant_q[3]), 32'd3);
      chk("t2_g4", 32'(grant_q[4]), 32'd0);
    end

    // silent core: QNaN and sticky error after TMO wait cycles; late results ignored
    bus.rsp_ready_i = '0;
    send(1, 16'h3F80);
    steps(TMO);
    chk("t3_pre_rsp", 32'(bus.rsp_valid_o), 32'h0);
    chk("t3_pre_err", 32'(err_timeout_o), 32'h0);
    step();
    chk("t3_rsp_valid", 32'(bus.rsp_valid_o), 32'h2);
    chk("t3_rsp_qnan", 32'(bus.rsp_data_o), 32'h7FC0);
    chk("t3_err", 32'(err_timeout_o), 32'h1);
    core_pulse(16'h1111);
    chk("t3_late_data", 32'(bus.rsp_data_o), 32'h7FC0);
    chk("t3_late_valid", 32'(bus.rsp_valid_o), 32'h2);
    bus.rsp_ready_i = 4'b0010;
    step();
    bus.rsp_ready_i = '0;
    core_pulse(16'h2222);
    chk("t3_idle_rsp", 32'(bus.rsp_valid_o), 32'h0);
    chk("t3_err_sticky", 32'(err_timeout_o), 32'h1);
    err_clr_i = 1'b1;
    step();
    err_clr_i = 1'b0;
    chk("t3_err_clr", 32'(err_timeout_o), 32'h0);

    // owner stalls the response for 5 cycles while non-owners are ready and requester 0 waits
    bus.rsp_ready_i = 4'b0111;
    send(3, 16'h4080);
    steps(2);
    core_pulse(16'h4000);
    bus.req_data_i  = (bus.req_data_i & ~64'hFFFF) | 64'h3F80;
    bus.req_valid_i = 4'b0001;
    #1;
    p0 = core_pulses;
    for (int c = 0; c < 5; c++) begin
      chk("t4_hold_valid", 32'(bus.rsp_valid_o), 32'h8);
      chk("t4_hold_data", 32'(bus.rsp_data_o), 32'h4000);
      chk("t4_hold_ready", 32'(bus.req_ready_o), 32'h0);
      chk("t4_hold_core", 32'(core_valid_o), 32'h0);
      step();
    end
    chk("t4_no_pulse", 32'(core_pulses - p0), 32'h0);
    bus.rsp_ready_i = 4'b1000;
    step();
    chk("t4_back_to_back", 32'(bus.req_ready_o), 32'h1);
    step();
    bus.req_valid_i = '0;
    bus.rsp_ready_i = 4'hF;
    step();
    core_pulse(16'h0000);
    step();

    // reset mid-WAIT abandons the operation; the pointer restarts at 0
    send(2, 16'h4100);
    steps(5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    rc0 = rsp_cycles;
    steps(2);
    core_pulse(16'h3F00);
    steps(3);
    chk("t5_no_rsp", 32'(rsp_cycles - rc0), 32'h0);
    grant_q.delete();
    bus.req_data_i  = {16'h4300, 16'h0000, 16'h4280, 16'h0000};
    bus.req_valid_i = 4'b1010;
    step();
    bus.req_valid_i = '0;
    chk("t5_grants", 32'(grant_q.size()), 32'd1);
    if (grant_q.size() > 0) chk("t5_first_grant", 32'(grant_q[0]), 32'd1);
    step();
    core_pulse(16'h4000);
    step();

    // core answers in the very cycle the timeout would fire: the core wins
    send(0, 16'h4000);
    steps(TMO);
    core_pulse(16'h3F80);
    chk("t6_rsp_valid", 32'(bus.rsp_valid_o), 32'h1);
    chk("t6_rsp_data", 32'(bus.rsp_data_o), 32'h3F80);
    chk("t6_err", 32'(err_timeout_o), 32'h0);
    steps(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/flog_arbiter.md
FLOG_ARBITER -- requirements
Module: flog_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, SHALL set the number of requester ports (2..8).
REQ-002 Parameter TIMEOUT, default 255, SHALL set the max cycles to wait for a core result.
REQ-003 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid_i  input  N_REQ  per-requester request valid.
REQ-006 req_data_i  input  16*N_REQ  bfloat16 operands, requester i in bits [16i+15:16i], {sign, exp[7:0], fract[6:0]}.
REQ-007 req_ready_o  output  N_REQ  one-hot acceptance; a request transfers when valid and ready are both 1.
REQ-008 rsp_valid_o  output  N_REQ  one-hot result valid for the owning requester.
REQ-009 rsp_data_o  output  16  bfloat16 log2 result, shared by all requesters.
REQ-010 rsp_ready_i  input  N_REQ  per-requester result acceptance.
REQ-011 core_valid_o  output  1  single-cycle start pulse to the shared flog core.
REQ-012 core_sign_o, core_exp_o, core_fract_o  output  1/8/7  operand to the core.
REQ-013 core_valid_i  input  1  core result strobe.
REQ-014 core_s_i, core_e_i, core_f_i  input  1/8/7  core result fields.
REQ-015 err_timeout_o  output  1  sticky timeout flag.
REQ-016 err_clr_i  input  1  clears err_timeout_o.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; at most one operation SHALL be in flight.
REQ-018 IDLE: when any req_valid_i bit is set, the arbiter SHALL raise req_ready_o for exactly one requester, chosen round-robin, in the same cycle, latch operand and owner ID, and go to ISSUE.
REQ-019 Round-robin: priority pointer SHALL start at 0; after granting i the search SHALL begin at (i+1) mod N_REQ.
REQ-020 req_ready_o SHALL be 0 in every state other than IDLE.
REQ-021 ISSUE: core_valid_o SHALL be 1 for exactly one cycle; next state WAIT; the timeout counter SHALL clear.
REQ-022 core_sign_o/exp_o/fract_o SHALL hold the latched operand from ISSUE until leaving WAIT.
REQ-023 WAIT: on core_valid_i, {core_s_i, core_e_i, core_f_i} SHALL be latched into the result register; next state RESP.
REQ-024 WAIT: the counter SHALL increment each cycle; on reaching TIMEOUT without core_valid_i, the result SHALL be 16'h7FC0 (QNaN), err_timeout_o SHALL set, and the next state SHALL be RESP.
REQ-025 If core_valid_i and the timeout occur in the same cycle, the core result SHALL win and err_timeout_o SHALL stay unchanged.
REQ-026 core_valid_i outside WAIT SHALL be ignored (late result discarded).
REQ-027 RESP: rsp_valid_o SHALL be the owner's one-hot bit and rsp_data_o the result register, both stable until the owner's rsp_ready_i is 1; that cycle the FSM SHALL return to IDLE.
REQ-028 rsp_ready_i bits of non-owners SHALL have no effect.
REQ-029 Minimum request-to-response latency SHALL be 3 cycles plus core latency; back-to-back operations SHALL need no idle cycle beyond the RESP-to-IDLE return.
REQ-030 err_clr_i SHALL clear err_timeout_o, except that a simultaneous timeout SHALL set it (set wins).

Reset
REQ-031 rst SHALL force IDLE, pointer 0, counter 0, result and operand registers 0, err_timeout_o 0.
REQ-032 During and after rst: req_ready_o, rsp_valid_o and core_valid_o SHALL be 0; rsp_data_o SHALL be 16'h0000.
REQ-033 rst in WAIT or RESP SHALL abandon the operation without a response; a subsequent core_valid_i SHALL be ignored.

Verification
REQ-034 Requester 2 sends 16'h4000 (2.0), core model returns 16'h3F80 after 20 cycles -> one core_valid_o pulse with exp 8'h80, fract 0; rsp_valid_o=4'b0100; rsp_data_o=16'h3F80.
REQ-035 All four req_valid_i high from reset, rsp_ready_i all 1 -> grant order 0,1,2,3,0; never two ready bits set.
REQ-036 Core never responds -> exactly TIMEOUT cycles after ISSUE, rsp_data_o=16'h7FC0 and err_timeout_o=1; late core_valid_i ignored; err_clr_i clears the flag.
REQ-037 Owner holds rsp_ready_i=0 for 5 cycles -> rsp_valid_o and rsp_data_o stable, no core_valid_o, req_ready_o stays 0.
REQ-038 rst asserted mid-WAIT, then core_valid_i -> no rsp_valid_o; next request is served from pointer 0.
REQ-039 core_valid_i in the same cycle as the timeout -> core result returned, err_timeout_o stays 0.
